// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised sync FIFO.
package sync_fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  // Ceiling log2; used to size pointers (AW) and the occupancy counter (AW+1).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // True when value is a non-zero power of two.
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Streaming FIFO bus: write side, read side, occupancy flags and error flags.
// master = the block driving writes/reads, slave = the FIFO itself.
interface sync_fifo_flags_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = clog2(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// FIFO storage: DEPTH x DATA_W, synchronous write, asynchronous read.
// Not reset; the pointers in the parent decide which words are meaningful.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so the parent can either register it or present it directly.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through
// read data, programmable almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = MODE_REG
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_flags_if.slave bus
);

  localparam int          AW         = clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT  = (AW + 1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_CNT = (AW + 1)'(AEMPTY_TH);

  // Reject illegal configurations at elaboration time.
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flags: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flags: AEMPTY_TH must be in 0..DEPTH-1");
  end
  if (FWFT != MODE_REG && FWFT != MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_flags: FWFT must be 0 or 1");
  end

  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW:0]       count_reg, count_next;
  logic              overflow_reg, underflow_reg;
  logic              full, empty;
  logic              rd_acc, wr_acc;
  logic [DATA_W-1:0] ram_rd_data;

  // Status flags are pure decodes of the registered occupancy.
  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // A read needs data; a write needs room, or a slot being freed by a same-cycle read.
  // Writing to an empty FIFO never bypasses to the read side.
  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || rd_acc);

  // Next pointer and occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_acc) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (rd_acc) rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and occupancy registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Sticky error flags: a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.wr_en && !wr_acc)  overflow_reg <= 1'b1;
      else if (bus.clr_err)      overflow_reg <= 1'b0;
      if (bus.rd_en && empty)    underflow_reg <= 1'b1;
      else if (bus.clr_err)      underflow_reg <= 1'b0;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (ram_rd_data)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head of queue is always visible; rd_en simply pops it.
    assign bus.rd_data  = ram_rd_data;
    assign bus.rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    // Capture the head word on an accepted read; valid pulses for one cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_reg  <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        rd_valid_reg <= rd_acc;
        if (rd_acc) rd_data_reg <= ram_rd_data;
      end
    end

    assign bus.rd_data  = rd_data_reg;
    assign bus.rd_valid = rd_valid_reg;
  end

  assign bus.count        = count_reg;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_reg >= AFULL_CNT);
  assign bus.almost_empty = (count_reg <= AEMPTY_CNT);
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: two instances (registered and FWFT read) share
// one stimulus stream; a queue model predicts read words and flags.
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;

  int checks = 0;
  int passed = 0;

  sync_fifo_flags_if #(.DATA_W(DW), .DEPTH(DP)) if0 ();
  sync_fifo_flags_if #(.DATA_W(DW), .DEPTH(DP)) if1 ();

  assign if0.wr_en = wr_en;  assign if1.wr_en = wr_en;
  assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
  assign if0.rd_en = rd_en;  assign if1.rd_en = rd_en;
  assign if0.clr_err = clr_err; assign if1.clr_err = clr_err;

  sync_fifo_flags #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0))
    dut_reg (.clk(clk), .rst(rst), .bus(if0));
  sync_fifo_flags #(.DATA_W(DW), .DEPTH(DP), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1))
    dut_fwft (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Per-instance observation vectors: index 0 = registered, 1 = FWFT.
  logic [3:0]    cnt_o [2];
  logic [DW-1:0] rd_o  [2];
  logic [1:0]    full_o, empty_o, af_o, ae_o, ovf_o, unf_o, rv_o;
  assign cnt_o[0] = if0.count;   assign cnt_o[1] = if1.count;
  assign rd_o[0]  = if0.rd_data; assign rd_o[1]  = if1.rd_data;
  assign full_o  = {if1.full, if0.full};
  assign empty_o = {if1.empty, if0.empty};
  assign af_o    = {if1.almost_full, if0.almost_full};
  assign ae_o    = {if1.almost_empty, if0.almost_empty};
  assign ovf_o   = {if1.overflow, if0.overflow};
  assign unf_o   = {if1.underflow, if0.underflow};
  assign rv_o    = {if1.rd_valid, if0.rd_valid};

  // Reference model and scoreboards.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  bit            m_ovf = 0, m_unf = 0;
  bit            last_racc = 0;
  logic          pre_v1;
  logic [DW-1:0] pre_d1;

  // One clock of stimulus; updates the model and captures the FWFT head pre-edge.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit clr);
    bit racc, wacc;
    wr_en = we; wr_data = wd; rd_en = re; clr_err = clr;
    #1;
    pre_v1 = rv_o[1];
    pre_d1 = rd_o[1];
    racc = re && (mq.size() > 0);
    wacc = we && ((mq.size() < DP) || racc);
    if (racc) begin
      logic [DW-1:0] v;
      v = mq.pop_front();
      exp0_q.push_back(v);
      exp1_q.push_back(v);
    end
    if (wacc) mq.push_back(wd);
    if (we && !wacc) m_ovf = 1; else if (clr) m_ovf = 0;
    if (re && !racc) m_unf = 1; else if (clr) m_unf = 0;
    last_racc = racc;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; clr_err = 0;
  endtask

  task automatic do_reset();
    rst = 1; wr_en = 1; wr_data = 8'hEE; rd_en = 1;
    @(posedge clk); #1;
    rst = 0; wr_en = 0; rd_en = 0;
    mq.delete(); exp0_q.delete(); exp1_q.delete();
    m_ovf = 0; m_unf = 0; last_racc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    step(0, 8'h00, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (cnt_o[d] !== 4'd0) $display("FAIL reset_count[%0d]: got %0d expected 0", d, cnt_o[d]); else passed++;
      checks++; if (empty_o[d] !== 1'b1 || ae_o[d] !== 1'b1) $display("FAIL reset_empty[%0d]: got e=%b ae=%b expected 1 1", d, empty_o[d], ae_o[d]); else passed++;
      checks++; if (full_o[d] !== 1'b0 || af_o[d] !== 1'b0) $display("FAIL reset_full[%0d]: got f=%b af=%b expected 0 0", d, full_o[d], af_o[d]); else passed++;
      checks++; if (rv_o[d] !== 1'b0) $display("FAIL reset_rd_valid[%0d]: got %b expected 0", d, rv_o[d]); else passed++;
      checks++; if (ovf_o[d] !== 1'b0 || unf_o[d] !== 1'b0) $display("FAIL reset_err[%0d]: got ovf=%b unf=%b expected 0 0", d, ovf_o[d], unf_o[d]); else passed++;
    end
    checks++; if (rd_o[0] !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_o[0]); else passed++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DP; i++) begin
      step(1, 8'(i), 0, 0);
      for (int d = 0; d < 2; d++) begin
        checks++; if (cnt_o[d] !== 4'(i)) $display("FAIL fill_count[%0d]: got %0d expected %0d", d, cnt_o[d], i); else passed++;
        checks++; if (ae_o[d] !== (i <= 1) || af_o[d] !== (i >= 6) || full_o[d] !== (i == DP) || empty_o[d] !== 1'b0)
          $display("FAIL fill_flags[%0d] n=%0d: got ae=%b af=%b f=%b e=%b expected %b %b %b 0", d, i, ae_o[d], af_o[d], full_o[d], empty_o[d], i <= 1, i >= 6, i == DP);
        else passed++;
      end
    end
    step(1, 8'hAA, 0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (ovf_o[d] !== m_ovf || cnt_o[d] !== 4'(mq.size())) $display("FAIL overflow[%0d]: got ovf=%b cnt=%0d expected %b %0d", d, ovf_o[d], cnt_o[d], m_ovf, mq.size()); else passed++;
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DP; i++) begin
      step(0, 8'h00, 1, 0);
      if (last_racc) begin
        logic [DW-1:0] e0, e1;
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        checks++; if (rv_o[0] !== 1'b1 || rd_o[0] !== e0) $display("FAIL drain_reg: got v=%b d=%h expected 1 %h", rv_o[0], rd_o[0], e0); else passed++;
        checks++; if (pre_v1 !== 1'b1 || pre_d1 !== e1) $display("FAIL drain_fwft: got v=%b d=%h expected 1 %h", pre_v1, pre_d1, e1); else passed++;
      end else begin
        checks++; $display("FAIL drain_accept: got no accepted read expected one at %0d", i);
      end
      checks++; if (cnt_o[0] !== 4'(mq.size())) $display("FAIL drain_count: got %0d expected %0d", cnt_o[0], mq.size()); else passed++;
    end
    step(0, 8'h00, 0, 0);
    checks++; if (rv_o[0] !== 1'b0) $display("FAIL rd_valid_pulse: got %b expected 0", rv_o[0]); else passed++;
    step(0, 8'h00, 1, 0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (unf_o[d] !== m_unf || cnt_o[d] !== 4'd0 || rv_o[d] !== 1'b0) $display("FAIL underflow[%0d]: got unf=%b cnt=%0d v=%b expected %b 0 0", d, unf_o[d], cnt_o[d], rv_o[d], m_unf); else passed++;
    end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= DP; i++) step(1, 8'(i), 0, 0);
    for (int i = 0; i < 3 + DP; i++) begin
      if (i < 3) step(1, 8'h55, 1, 0); else step(0, 8'h00, 1, 0);
      if (last_racc) begin
        logic [DW-1:0] e0, e1;
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        checks++; if (rv_o[0] !== 1'b1 || rd_o[0] !== e0) $display("FAIL full_rw_reg: got v=%b d=%h expected 1 %h", rv_o[0], rd_o[0], e0); else passed++;
        checks++; if (pre_d1 !== e1) $display("FAIL full_rw_fwft: got %h expected %h", pre_d1, e1); else passed++;
      end
      if (i < 3) begin
        checks++; if (cnt_o[1] !== 4'd8 || ovf_o !== 2'b00) $display("FAIL full_rw_count: got cnt=%0d ovf=%b expected 8 00", cnt_o[1], ovf_o); else passed++;
      end
    end
  endtask

  task automatic test_empty_rw_clr();
    step(1, 8'h33, 1, 0);
    for (int d = 0; d < 2; d++) begin
      checks++; if (cnt_o[d] !== 4'd1 || unf_o[d] !== m_unf) $display("FAIL empty_rw[%0d]: got cnt=%0d unf=%b expected 1 %b", d, cnt_o[d], unf_o[d], m_unf); else passed++;
    end
    step(0, 8'h00, 1, 0);
    if (last_racc) begin
      logic [DW-1:0] e0, e1;
      e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
      checks++; if (rd_o[0] !== e0) $display("FAIL empty_rw_reg: got %h expected %h", rd_o[0], e0); else passed++;
      checks++; if (pre_d1 !== e1) $display("FAIL empty_rw_fwft: got %h expected %h", pre_d1, e1); else passed++;
    end else begin
      checks++; $display("FAIL empty_rw_accept: got no accepted read expected one");
    end
    step(0, 8'h00, 0, 1);
    checks++; if (ovf_o !== 2'b00 || unf_o !== 2'b00) $display("FAIL clr_err: got ovf=%b unf=%b expected 00 00", ovf_o, unf_o); else passed++;
    for (int i = 0; i < DP; i++) step(1, 8'(8'h90 + i), 0, 0);
    step(1, 8'h99, 0, 1);
    checks++; if (ovf_o !== {2{m_ovf}}) $display("FAIL set_over_clr: got %b expected %b%b", ovf_o, m_ovf, m_ovf); else passed++;
    for (int i = 0; i < DP; i++) begin
      step(0, 8'h00, 1, 0);
      if (last_racc) begin
        logic [DW-1:0] e0;
        e0 = exp0_q.pop_front(); void'(exp1_q.pop_front());
        checks++; if (rd_o[0] !== e0) $display("FAIL drain2_reg: got %h expected %h", rd_o[0], e0); else passed++;
      end
    end
    step(0, 8'h00, 0, 1);
  endtask

  task automatic test_wrap_reset();
    step(1, 8'h40, 0, 0);
    for (int i = 1; i < 16; i++) begin
      step(1, 8'(8'h40 + i), 1, 0);
      if (last_racc) begin
        logic [DW-1:0] e0, e1;
        e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
        checks++; if (rd_o[0] !== e0 || pre_d1 !== e1) $display("FAIL wrap_data: got reg=%h fwft=%h expected %h %h", rd_o[0], pre_d1, e0, e1); else passed++;
      end
    end
    for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 0, 0);
    checks++; if (cnt_o[0] !== 4'd5 || cnt_o[1] !== 4'd5) $display("FAIL wrap_count: got %0d %0d expected 5 5", cnt_o[0], cnt_o[1]); else passed++;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      checks++; if (cnt_o[d] !== 4'd0 || empty_o[d] !== 1'b1 || rv_o[d] !== 1'b0) $display("FAIL midreset[%0d]: got cnt=%0d e=%b v=%b expected 0 1 0", d, cnt_o[d], empty_o[d], rv_o[d]); else passed++;
    end
    step(1, 8'h77, 0, 0);
    step(0, 8'h00, 1, 0);
    if (last_racc) begin
      logic [DW-1:0] e0, e1;
      e0 = exp0_q.pop_front(); e1 = exp1_q.pop_front();
      checks++; if (rd_o[0] !== e0 || rv_o[0] !== 1'b1) $display("FAIL post_reset_reg: got v=%b d=%h expected 1 %h", rv_o[0], rd_o[0], e0); else passed++;
      checks++; if (pre_d1 !== e1) $display("FAIL post_reset_fwft: got %h expected %h", pre_d1, e1); else passed++;
    end else begin
      checks++; $display("FAIL post_reset_accept: got no accepted read expected one");
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_rw();
    test_empty_rw_clr();
    test_wrap_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
